// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control sequencer:
//   - state_t     : FSM state encoding (IDLE/RUN/PAUSE/LAP), also driven on
//                   the state_o status port
//   - CNT_MAX_DEF : default debounce stable-time count (20 ms at 50 MHz)
//   - is_counting : output decode helper, high in the states where the time
//                   counter advances
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;

   // Time keeps advancing in LAP; only the display is frozen there.
   function automatic logic is_counting(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
// Synchronises one raw active-low push-button into sys_clk, debounces it and
// emits a single-cycle press pulse once the key has been stable low for
// CNT_MAX consecutive synchronised samples.
// Ports:
//   sys_clk   in  system clock
//   sys_rst_n in  asynchronous active-low reset
//   key_in    in  raw button level, active-low, asynchronous to sys_clk
//   key_flag  out one-cycle press pulse (registered)
// -----------------------------------------------------------------------------
module key_filter
   import stopwatch_pkg::*;
#(
   parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic key_flag
);

   logic        r_sync1;
   logic        r_sync2;
   logic [19:0] r_cnt;
   logic        r_flag;

   // Two-flop synchroniser; resets to the released-key level.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   // Stable-low counter: any released sample restarts it, saturation at
   // CNT_MAX stops a held key from producing further pulses.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt <= 20'd0;
      end else if (r_sync2) begin
         r_cnt <= 20'd0;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + 20'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Press pulse on the single step from CNT_MAX-1 to CNT_MAX.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_flag <= 1'b0;
      end else begin
         r_flag <= (!r_sync2) && (r_cnt == (CNT_MAX - 20'd1));
      end
   end

   assign key_flag = r_flag;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control sequencer for the stopwatch: debounces the start/stop and
// lap/reset keys and runs the IDLE/RUN/PAUSE/LAP FSM that drives the time
// counter and display controls. All outputs are registered and decoded from
// the next state, so a press pulse in cycle N is reflected in cycle N+1.
// Ports:
//   sys_clk   in  system clock (50 MHz)
//   sys_rst_n in  asynchronous active-low reset
//   key_ss    in  raw start/stop key, active-low
//   key_lr    in  raw lap/reset key, active-low
//   cnt_en    out count enable (RUN, LAP)
//   cnt_clr   out one-cycle time-counter clear
//   lap_hold  out display freeze (LAP)
//   state_o   out current FSM state code
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_ss,
   input  logic       key_lr,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       lap_hold,
   output logic [1:0] state_o
);

   logic   w_ss_flag;
   logic   w_lr_flag;
   state_t r_state;
   state_t w_state_next;
   logic   w_clr_next;
   logic   r_cnt_en;
   logic   r_cnt_clr;
   logic   r_lap_hold;

   key_filter #(.CNT_MAX(CNT_MAX)) u_ss (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_in    (key_ss),
      .key_flag  (w_ss_flag)
   );

   key_filter #(.CNT_MAX(CNT_MAX)) u_lr (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_in    (key_lr),
      .key_flag  (w_lr_flag)
   );

   // Next-state logic; start/stop takes priority, so a coincident lap/reset
   // pulse is simply dropped.
   always_comb begin
      w_state_next = r_state;
      w_clr_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_flag) begin
               w_state_next = ST_RUN;
            end else if (w_lr_flag) begin
               w_clr_next = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_ss_flag) begin
               w_state_next = ST_PAUSE;
            end else if (w_lr_flag) begin
               w_state_next = ST_LAP;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         ST_LAP: begin
            if (w_ss_flag) begin
               w_state_next = ST_PAUSE;
            end else if (w_lr_flag) begin
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (w_ss_flag) begin
               w_state_next = ST_RUN;
            end else if (w_lr_flag) begin
               w_state_next = ST_IDLE;
               w_clr_next   = 1'b1;
            end else begin
               w_state_next = ST_PAUSE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_clr_next   = 1'b0;
         end
      endcase
   end

   // State register and outputs decoded from the next state.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt_en   <= 1'b0;
         r_cnt_clr  <= 1'b0;
         r_lap_hold <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt_en   <= is_counting(w_state_next);
         r_cnt_clr  <= w_clr_next;
         r_lap_hold <= (w_state_next == ST_LAP);
      end
   end

   assign cnt_en   = r_cnt_en;
   assign cnt_clr  = r_cnt_clr;
   assign lap_hold = r_lap_hold;
   assign state_o  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed plus randomised stimulus for stopwatch_ctrl with CNT_MAX = 9.
// Reference model: a key produces a press pulse two cycles (synchroniser)
// after the clock edge at which it has been sampled low for exactly CNT_MAX
// consecutive edges; the FSM reacts one cycle after the pulse.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int CM = 9;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       key_ss;
   logic       key_lr;
   logic       cnt_en;
   logic       cnt_clr;
   logic       lap_hold;
   logic [1:0] state_o;

   int n_vec = 0;
   int n_err = 0;

   // model: zero-run lengths, their 2-edge delay line, pulses, FSM
   int zr_ss, a_ss, b_ss, zr_lr, a_lr, b_lr;
   bit fl_ss, fl_lr;
   int m_state;
   bit m_clr;

   stopwatch_ctrl #(.CNT_MAX(20'd9)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_ss    (key_ss),
      .key_lr    (key_lr),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .lap_hold  (lap_hold),
      .state_o   (state_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      zr_ss = 0; a_ss = 0; b_ss = 0;
      zr_lr = 0; a_lr = 0; b_lr = 0;
      fl_ss = 1'b0; fl_lr = 1'b0;
      m_state = 0; m_clr = 1'b0;
   endfunction

   task automatic check_all();
      chk("state_o",  state_o,  2'(m_state));
      chk("cnt_en",   {1'b0, cnt_en},   {1'b0, (m_state == 1) || (m_state == 3)});
      chk("lap_hold", {1'b0, lap_hold}, {1'b0, (m_state == 3)});
      chk("cnt_clr",  {1'b0, cnt_clr},  {1'b0, m_clr});
      chk("ss_flag",  {1'b0, dut.u_ss.key_flag}, {1'b0, fl_ss});
      chk("lr_flag",  {1'b0, dut.u_lr.key_flag}, {1'b0, fl_lr});
   endtask

   // one clock: advance the model with the key levels seen at the edge
   task automatic step();
      bit nf_ss, nf_lr;
      @(posedge sys_clk);
      if (!sys_rst_n) begin
         model_reset();
      end else begin
         m_clr = 1'b0;
         if (fl_ss) begin
            case (m_state)
               0: m_state = 1;
               1: m_state = 2;
               2: m_state = 1;
               default: m_state = 2;
            endcase
         end else if (fl_lr) begin
            case (m_state)
               0: m_clr = 1'b1;
               1: m_state = 3;
               2: begin m_state = 0; m_clr = 1'b1; end
               default: m_state = 1;
            endcase
         end
         nf_ss = (b_ss == CM);
         nf_lr = (b_lr == CM);
         b_ss = a_ss; b_lr = a_lr;
         zr_ss = key_ss ? 0 : ((zr_ss < 1000) ? zr_ss + 1 : zr_ss);
         zr_lr = key_lr ? 0 : ((zr_lr < 1000) ? zr_lr + 1 : zr_lr);
         a_ss = zr_ss; a_lr = zr_lr;
         fl_ss = nf_ss; fl_lr = nf_lr;
      end
      #1;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // press = 14 cycles low (long enough for one pulse), then 14 released
   task automatic press(input bit ss, input bit lr);
      if (ss) key_ss = 1'b0;
      if (lr) key_lr = 1'b0;
      steps(14);
      key_ss = 1'b1;
      key_lr = 1'b1;
      steps(14);
   endtask

   initial begin
      int hold_ss, hold_lr;
      sys_rst_n = 1'b0;
      key_ss    = 1'b1;
      key_lr    = 1'b1;
      model_reset();
      steps(3);
      sys_rst_n = 1'b1;
      steps(20);

      // single clean ss press: pulse 11 cycles after the low edge
      key_ss = 1'b0;
      steps(10);
      chk("ss_no_early_pulse", {1'b0, dut.u_ss.key_flag}, 2'd0);
      step();
      chk("ss_pulse_at_11", {1'b0, dut.u_ss.key_flag}, 2'd1);
      step();
      chk("run_after_pulse", state_o, 2'd1);
      chk("run_cnt_en", {1'b0, cnt_en}, 2'd1);
      steps(18);
      key_ss = 1'b1;
      steps(15);
      chk("run_held", state_o, 2'd1);

      // bouncing ss: low5 high1 low5 high1 then steady low -> one transition
      key_ss = 1'b0; steps(5);
      key_ss = 1'b1; steps(1);
      key_ss = 1'b0; steps(5);
      key_ss = 1'b1; steps(1);
      key_ss = 1'b0; steps(20);
      key_ss = 1'b1; steps(14);
      chk("bounce_pause", state_o, 2'd2);

      // PAUSE -> RUN -> LAP -> PAUSE -> IDLE (with clear)
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      chk("lap_state", state_o, 2'd3);
      chk("lap_hold_on", {1'b0, lap_hold}, 2'd1);
      press(1'b1, 1'b0);
      chk("lap_to_pause", state_o, 2'd2);
      press(1'b0, 1'b1);
      chk("pause_to_idle", state_o, 2'd0);

      // simultaneous presses from IDLE: ss wins, no clear
      press(1'b1, 1'b1);
      chk("simul_run", state_o, 2'd1);

      // into LAP, then reset with the ss debounce count at 5
      press(1'b0, 1'b1);
      key_ss = 1'b0;
      steps(7);
      chk("ss_cnt_5", dut.u_ss.r_cnt[1:0], 2'd1);
      sys_rst_n = 1'b0;
      #1;
      chk("async_state", state_o, 2'd0);
      chk("async_en",  {1'b0, cnt_en},  2'd0);
      chk("async_lap", {1'b0, lap_hold}, 2'd0);
      chk("async_clr", {1'b0, cnt_clr}, 2'd0);
      key_ss = 1'b1;
      steps(3);
      sys_rst_n = 1'b1;
      steps(15);
      chk("post_reset_idle", state_o, 2'd0);

      // key held through reset release needs the full count afterwards
      key_ss = 1'b0;
      steps(4);
      sys_rst_n = 1'b0;
      steps(2);
      sys_rst_n = 1'b1;
      steps(10);
      chk("held_no_pulse_yet", state_o, 2'd0);
      steps(3);
      chk("held_then_run", state_o, 2'd1);
      key_ss = 1'b1;
      steps(12);

      // randomised key activity with random hold lengths
      hold_ss = 0;
      hold_lr = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold_ss == 0) begin
            key_ss  = 1'($urandom_range(0, 1));
            hold_ss = $urandom_range(1, 25);
         end
         if (hold_lr == 0) begin
            key_lr  = 1'($urandom_range(0, 1));
            hold_lr = $urandom_range(1, 25);
         end
         hold_ss--;
         hold_lr--;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
